// File: rtl/pmp_arb_pkg.sv
// Shared types for the PMP check arbiter.
// Optional fault log: PMP_ARB_FAULT_LOG_EN.
package pmp_arb_pkg;

  localparam int DEF_N_REQ = 2;
  localparam int DEF_PLEN = 34;
  localparam int DEF_PMP_LEN = 32;
  localparam int DEF_NR_ENTRIES = 4;

  function automatic int id_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_ID_W = id_width(DEF_N_REQ);

  typedef logic [2:0] pmp_access_t;
  typedef logic [1:0] priv_lvl_t;

  localparam pmp_access_t ACC_R = 3'b001;
  localparam pmp_access_t ACC_W = 3'b010;
  localparam pmp_access_t ACC_X = 3'b100;

  localparam priv_lvl_t PRIV_U = 2'd0;
  localparam priv_lvl_t PRIV_S = 2'd1;
  localparam priv_lvl_t PRIV_M = 2'd3;

  typedef enum logic [1:0] {
    A_OFF   = 2'd0,
    A_TOR   = 2'd1,
    A_NA4   = 2'd2,
    A_NAPOT = 2'd3
  } addr_mode_e;

  typedef struct packed {
    logic        locked;
    logic [1:0]  reserved;
    addr_mode_e  addr_mode;
    pmp_access_t access_type;
  } pmpcfg_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    RESP  = 2'd2
  } state_e;

  typedef struct packed {
    logic [DEF_PLEN-1:0] addr;
    pmp_access_t         access;
    priv_lvl_t           priv;
    logic [DEF_ID_W-1:0] id;
  } pmp_req_t;

endpackage

// File: rtl/pmp_arb_if.sv
// Requester-side request bundle and shared
// response channel of the PMP check arbiter.
interface pmp_arb_if #(
  parameter int N_REQ = pmp_arb_pkg::DEF_N_REQ,
  parameter int PLEN = pmp_arb_pkg::DEF_PLEN,
  parameter int ID_W = pmp_arb_pkg::DEF_ID_W
) ();
  logic [N_REQ-1:0]           req_valid;
  logic [N_REQ-1:0]           req_ready;
  logic [N_REQ-1:0][PLEN-1:0] req_addr;
  logic [N_REQ-1:0][2:0]      req_access;
  logic [N_REQ-1:0][1:0]      req_priv;
  logic                       resp_valid;
  logic                       resp_ready;
  logic [ID_W-1:0]            resp_id;
  logic                       resp_allow;

  modport master (
    output req_valid, req_addr,
    output req_access, req_priv,
    output resp_ready,
    input  req_ready, resp_valid,
    input  resp_id, resp_allow
  );

  modport slave (
    input  req_valid, req_addr,
    input  req_access, req_priv,
    input  resp_ready,
    output req_ready, resp_valid,
    output resp_id, resp_allow
  );
endinterface

// File: rtl/pmp.sv
// Combinational PMP checker: lowest matching
// entry decides; no match allows M-mode only.
module pmp
  import pmp_arb_pkg::*;
#(
  parameter int PLEN = 34,
  parameter int PMP_LEN = 32,
  parameter int NR_ENTRIES = 4
) (
  input  logic [PLEN-1:0]                      addr_i,
  input  pmp_access_t                          access_type_i,
  input  priv_lvl_t                            priv_lvl_i,
  input  logic [NR_ENTRIES-1:0][PMP_LEN-1:0]   conf_addr_i,
  input  pmpcfg_t [NR_ENTRIES-1:0]             conf_i,
  output logic                                 allow_o
);
  logic [PMP_LEN-1:0] word;
  logic [PMP_LEN-1:0] mask;
  logic [PMP_LEN-1:0] prev;
  logic hit;
  logic matched;
  logic unused_lo;
  logic [NR_ENTRIES-1:0] unused_rsv;

  assign word = addr_i[PMP_LEN+1:2];
  assign unused_lo = ^addr_i[1:0];

  for (genvar g = 0; g < NR_ENTRIES; g++) begin : g_rsv
    assign unused_rsv[g] = ^conf_i[g].reserved;
  end

  always_comb begin
    allow_o = (priv_lvl_i == PRIV_M);
    matched = 1'b0;
    hit = 1'b0;
    mask = '0;
    prev = '0;
    for (int i = 0; i < NR_ENTRIES; i++) begin
      // trailing ones plus the first zero are don't-care
      mask = conf_addr_i[i] ^ (conf_addr_i[i] + 1'b1);
      unique case (conf_i[i].addr_mode)
        A_TOR:   hit = (word >= prev) &&
                       (word < conf_addr_i[i]);
        A_NA4:   hit = (word == conf_addr_i[i]);
        A_NAPOT: hit = ((word ^ conf_addr_i[i])
                       & ~mask) == '0;
        default: hit = 1'b0;
      endcase
      if (hit && !matched) begin
        matched = 1'b1;
        allow_o = ((priv_lvl_i == PRIV_M) &&
                   !conf_i[i].locked) ||
                  ((access_type_i &
                    conf_i[i].access_type)
                   == access_type_i);
      end
      prev = conf_addr_i[i];
    end
  end
endmodule

// File: rtl/pmp_rr_arb.sv
// Round-robin one-hot grant; the pointer moves
// past the winner only when a grant is issued.
module pmp_rr_arb #(
  parameter int N = 2,
  parameter int ID_W = 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            en_i,
  input  logic [N-1:0]    req_i,
  output logic [N-1:0]    gnt_o,
  output logic [ID_W-1:0] idx_o
);
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic found;
  int idx;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    idx = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N) idx = idx - N;
      if (en_i && !found && req_i[idx]) begin
        found = 1'b1;
        gnt_o[idx] = 1'b1;
        idx_o = ID_W'(idx);
      end
    end
    ptr_d = ptr_q;
    if (found) begin
      ptr_d = (idx_o == ID_W'(N - 1)) ?
              '0 : idx_o + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end
endmodule

// File: rtl/pmp_check_arbiter.sv
// Time-shares one PMP checker among requesters.
// Fault log ports under PMP_ARB_FAULT_LOG_EN.
module pmp_check_arbiter
  import pmp_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int PLEN = DEF_PLEN,
  parameter int PMP_LEN = DEF_PMP_LEN,
  parameter int NR_ENTRIES = DEF_NR_ENTRIES
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       flush_i,
  input  logic [NR_ENTRIES-1:0][PMP_LEN-1:0]
                     conf_addr_i,
  input  pmpcfg_t [NR_ENTRIES-1:0] conf_i,
  output logic       busy_o,
`ifdef PMP_ARB_FAULT_LOG_EN
  output logic       fault_valid_o,
  output logic [PLEN-1:0] fault_addr_o,
  output logic [id_width(N_REQ)-1:0] fault_id_o,
  input  logic       fault_clear_i,
`endif
  pmp_arb_if.slave   bus
);
  localparam int ID_W = id_width(N_REQ);

  state_e   state_q, state_d;
  pmp_req_t stage_q, stage_d;
  logic     allow_q, allow_d;
  logic     pmp_allow;
  logic     arb_en;
  logic     hs;
  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_idx;

  assign arb_en = (state_q == IDLE) && !flush_i;
  assign hs = |gnt;

  pmp_rr_arb #(.N(N_REQ), .ID_W(ID_W)) u_arb (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (arb_en),
    .req_i  (bus.req_valid),
    .gnt_o  (gnt),
    .idx_o  (gnt_idx)
  );

  pmp #(
    .PLEN       (PLEN),
    .PMP_LEN    (PMP_LEN),
    .NR_ENTRIES (NR_ENTRIES)
  ) u_pmp (
    .addr_i        (stage_q.addr),
    .access_type_i (stage_q.access),
    .priv_lvl_i    (stage_q.priv),
    .conf_addr_i   (conf_addr_i),
    .conf_i        (conf_i),
    .allow_o       (pmp_allow)
  );

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    allow_d = allow_q;
    unique case (state_q)
      IDLE: if (hs) begin
        stage_d.addr = bus.req_addr[gnt_idx];
        stage_d.access = bus.req_access[gnt_idx];
        stage_d.priv = bus.req_priv[gnt_idx];
        stage_d.id = gnt_idx;
        state_d = CHECK;
      end
      CHECK: begin
        allow_d = pmp_allow;
        state_d = RESP;
      end
      RESP: if (bus.resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      stage_q <= '0;
      allow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      allow_q <= allow_d;
    end
  end

  assign bus.req_ready = gnt;
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_id = stage_q.id;
  assign bus.resp_allow = allow_q;
  assign busy_o = (state_q != IDLE);

`ifdef PMP_ARB_FAULT_LOG_EN
  logic fault_valid_q, fault_valid_d;
  logic [PLEN-1:0] fault_addr_q, fault_addr_d;
  logic [ID_W-1:0] fault_id_q, fault_id_d;
  logic deny;

  // a denial is final once CHECK completes unflushed
  assign deny = (state_q == CHECK) &&
                !flush_i && !pmp_allow;

  always_comb begin
    fault_valid_d = fault_valid_q;
    fault_addr_d = fault_addr_q;
    fault_id_d = fault_id_q;
    if (fault_clear_i) begin
      fault_valid_d = 1'b0;
    end else if (deny && !fault_valid_q) begin
      fault_valid_d = 1'b1;
      fault_addr_d = stage_q.addr;
      fault_id_d = stage_q.id;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fault_valid_q <= 1'b0;
      fault_addr_q <= '0;
      fault_id_q <= '0;
    end else begin
      fault_valid_q <= fault_valid_d;
      fault_addr_q <= fault_addr_d;
      fault_id_q <= fault_id_d;
    end
  end

  assign fault_valid_o = fault_valid_q;
  assign fault_addr_o = fault_addr_q;
  assign fault_id_o = fault_id_q;
`endif
endmodule

// File: tb/tb_pmp_check_arbiter.sv
// Directed bench for pmp_check_arbiter.
// Fault-log checks under PMP_ARB_FAULT_LOG_EN.
module tb_pmp_check_arbiter
  import pmp_arb_pkg::*;
;
  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  logic busy;
  logic [3:0][31:0] conf_addr;
  pmpcfg_t [3:0] conf;
  int nvec = 0;
  int nerr = 0;

  localparam logic [33:0] A0 = 34'h01D980004;
  localparam logic [33:0] A1 = 34'h00D980008;
  localparam logic [33:0] A2 = 34'h000980010;
  localparam logic [33:0] A2_TOP = 34'h0009800FF;
  localparam logic [33:0] A2_OUT = 34'h000980100;
  localparam logic [7:0] CFG0 = 8'h19;
  localparam logic [7:0] CFG0_OFF = 8'h01;

`ifdef PMP_ARB_FAULT_LOG_EN
  logic fault_valid;
  logic [33:0] fault_addr;
  logic fault_id;
  logic fault_clear;
`endif

  pmp_arb_if #(.N_REQ(2), .PLEN(34), .ID_W(1)) bus ();

  pmp_check_arbiter dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .flush_i     (flush),
    .conf_addr_i (conf_addr),
    .conf_i      (conf),
    .busy_o      (busy),
`ifdef PMP_ARB_FAULT_LOG_EN
    .fault_valid_o (fault_valid),
    .fault_addr_o  (fault_addr),
    .fault_id_o    (fault_id),
    .fault_clear_i (fault_clear),
`endif
    .bus         (bus)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int id,
                       input logic [33:0] a,
                       input logic [2:0] acc,
                       input logic [1:0] pv);
    bus.req_valid[id] = 1'b1;
    bus.req_addr[id] = a;
    bus.req_access[id] = acc;
    bus.req_priv[id] = pv;
    cyc();
    bus.req_valid[id] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    bus.req_valid = '0;
    bus.req_addr = '0;
    bus.req_access = '0;
    bus.req_priv = '0;
    bus.resp_ready = 1'b0;
`ifdef PMP_ARB_FAULT_LOG_EN
    fault_clear = 1'b0;
`endif
    conf_addr[3] = 32'h0;
    conf_addr[2] = 32'h0026001F;
    conf_addr[1] = 32'h03660001;
    conf_addr[0] = 32'h07660000;
    conf[3] = 8'h00;
    conf[2] = 8'h1F;
    conf[1] = 8'h18;
    conf[0] = CFG0;
    repeat (2) cyc();
    nvec++;
    if (bus.resp_valid !== 1'b0 || busy !== 1'b0) begin
      nerr++;
      $display("FAIL reset_state valid=%b busy=%b want 0 0",
               bus.resp_valid, busy);
    end
    nvec++;
    if (bus.resp_id !== 1'b0 || bus.resp_allow !== 1'b0
        || bus.req_ready !== 2'b00) begin
      nerr++;
      $display("FAIL reset_out id=%b allow=%b rdy=%b want 0",
               bus.resp_id, bus.resp_allow, bus.req_ready);
    end
`ifdef PMP_ARB_FAULT_LOG_EN
    nvec++;
    if (fault_valid !== 1'b0) begin
      nerr++;
      $display("FAIL reset_fault got=%b want 0", fault_valid);
    end
`endif
    rst_n = 1'b1;
    cyc();
  endtask

  typedef struct {
    int          id;
    logic [33:0] addr;
    logic [2:0]  acc;
    logic [1:0]  pv;
    logic        allow;
  } vec_t;

  task automatic test_basic();
    vec_t v[8];
    logic [1:0] er;
    v[0] = '{0, A0, ACC_R, PRIV_U, 1'b1};
    v[1] = '{0, A0, ACC_W, PRIV_U, 1'b0};
    v[2] = '{1, A1, ACC_R, PRIV_S, 1'b0};
    v[3] = '{1, A2, ACC_W, PRIV_U, 1'b1};
    v[4] = '{0, A2_TOP, ACC_X, PRIV_U, 1'b1};
    v[5] = '{1, A2_OUT, ACC_R, PRIV_U, 1'b0};
    v[6] = '{0, A2_OUT, ACC_R, PRIV_M, 1'b1};
    v[7] = '{1, A1, ACC_W, PRIV_M, 1'b1};
    for (int i = 0; i < 8; i++) begin
      er = 2'b01 << v[i].id;
      bus.req_valid[v[i].id] = 1'b1;
      bus.req_addr[v[i].id] = v[i].addr;
      bus.req_access[v[i].id] = v[i].acc;
      bus.req_priv[v[i].id] = v[i].pv;
      #1;
      nvec++;
      if (bus.req_ready !== er) begin
        nerr++;
        $display("FAIL basic%0d_ready got=%b want %b",
                 i, bus.req_ready, er);
      end
      cyc();
      bus.req_valid = '0;
      nvec++;
      if (busy !== 1'b1 || bus.resp_valid !== 1'b0) begin
        nerr++;
        $display("FAIL basic%0d_check busy=%b valid=%b want 1 0",
                 i, busy, bus.resp_valid);
      end
      cyc();
      nvec++;
      if (bus.resp_valid !== 1'b1 ||
          bus.resp_id !== 1'(v[i].id) ||
          bus.resp_allow !== v[i].allow) begin
        nerr++;
        $display("FAIL basic%0d_resp v=%b id=%b al=%b want 1 %0d %b",
                 i, bus.resp_valid, bus.resp_id,
                 bus.resp_allow, v[i].id, v[i].allow);
      end
`ifdef PMP_ARB_FAULT_LOG_EN
      if (i >= 1) begin
        nvec++;
        if (fault_valid !== 1'b1 || fault_addr !== A0 ||
            fault_id !== 1'b0) begin
          nerr++;
          $display("FAIL basic%0d_fault v=%b a=%h id=%b want 1 %h 0",
                   i, fault_valid, fault_addr, fault_id, A0);
        end
      end
`endif
      bus.resp_ready = 1'b1;
      cyc();
      bus.resp_ready = 1'b0;
      nvec++;
      if (bus.resp_valid !== 1'b0 || busy !== 1'b0) begin
        nerr++;
        $display("FAIL basic%0d_idle valid=%b busy=%b want 0 0",
                 i, bus.resp_valid, busy);
      end
    end
  endtask

  task automatic test_back_to_back();
    int g = 0;
    int r = 0;
    logic exp_id[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [1:0] er;
    bus.req_addr[0] = A2;
    bus.req_addr[1] = A0;
    bus.req_access[0] = ACC_W;
    bus.req_access[1] = ACC_R;
    bus.req_priv[0] = PRIV_U;
    bus.req_priv[1] = PRIV_U;
    bus.req_valid = 2'b11;
    bus.resp_ready = 1'b1;
    #1;
    for (int c = 0; c < 12; c++) begin
      if (bus.req_ready !== 2'b00) begin
        er = (g < 4) ? (2'b01 << exp_id[g]) : 2'b00;
        nvec++;
        if (bus.req_ready !== er || c != 3 * g) begin
          nerr++;
          $display("FAIL b2b_grant%0d got=%b@%0d want %b@%0d",
                   g, bus.req_ready, c, er, 3 * g);
        end
        g++;
      end
      if (bus.resp_valid === 1'b1) begin
        nvec++;
        if (r >= 4 || bus.resp_id !== exp_id[r] ||
            c != 3 * r + 2 || bus.resp_allow !== 1'b1) begin
          nerr++;
          $display("FAIL b2b_resp%0d id=%b al=%b@%0d want %b 1@%0d",
                   r, bus.resp_id, bus.resp_allow, c,
                   exp_id[r % 4], 3 * r + 2);
        end
        r++;
      end
      cyc();
    end
    bus.req_valid = '0;
    bus.resp_ready = 1'b0;
    nvec++;
    if (g != 4 || r != 4) begin
      nerr++;
      $display("FAIL b2b_count grants=%0d resps=%0d want 4 4",
               g, r);
    end
  endtask

  task automatic test_stall();
    issue(0, A0, ACC_R, PRIV_U);
    cyc();
    bus.req_valid[1] = 1'b1;
    bus.req_addr[1] = A2;
    bus.req_access[1] = ACC_R;
    bus.req_priv[1] = PRIV_U;
    conf[0] = CFG0_OFF;
    for (int k = 0; k < 5; k++) begin
      #1;
      nvec++;
      if (bus.resp_valid !== 1'b1 || bus.resp_allow !== 1'b1 ||
          bus.resp_id !== 1'b0 || bus.req_ready !== 2'b00) begin
        nerr++;
        $display("FAIL stall%0d v=%b al=%b id=%b rdy=%b want 1 1 0 00",
                 k, bus.resp_valid, bus.resp_allow,
                 bus.resp_id, bus.req_ready);
      end
      cyc();
    end
    bus.resp_ready = 1'b1;
    cyc();
    bus.resp_ready = 1'b0;
    conf[0] = CFG0;
    #1;
    nvec++;
    if (bus.resp_valid !== 1'b0 || busy !== 1'b0 ||
        bus.req_ready !== 2'b10) begin
      nerr++;
      $display("FAIL stall_exit v=%b busy=%b rdy=%b want 0 0 10",
               bus.resp_valid, busy, bus.req_ready);
    end
    bus.req_valid = '0;
  endtask

  task automatic test_flush();
    issue(0, A2, ACC_R, PRIV_U);
    flush = 1'b1;
    bus.req_valid[1] = 1'b1;
    bus.req_addr[1] = A2;
    bus.req_access[1] = ACC_W;
    bus.req_priv[1] = PRIV_U;
    #1;
    nvec++;
    if (bus.req_ready !== 2'b00) begin
      nerr++;
      $display("FAIL flush_check_rdy got=%b want 00",
               bus.req_ready);
    end
    cyc();
    nvec++;
    if (bus.resp_valid !== 1'b0 || busy !== 1'b0 ||
        bus.req_ready !== 2'b00) begin
      nerr++;
      $display("FAIL flush_idle v=%b busy=%b rdy=%b want 0 0 00",
               bus.resp_valid, busy, bus.req_ready);
    end
    flush = 1'b0;
    #1;
    nvec++;
    if (bus.req_ready !== 2'b10) begin
      nerr++;
      $display("FAIL flush_regrant got=%b want 10",
               bus.req_ready);
    end
    cyc();
    bus.req_valid = '0;
    cyc();
    nvec++;
    if (bus.resp_valid !== 1'b1 || bus.resp_id !== 1'b1 ||
        bus.resp_allow !== 1'b1) begin
      nerr++;
      $display("FAIL flush_next v=%b id=%b al=%b want 1 1 1",
               bus.resp_valid, bus.resp_id, bus.resp_allow);
    end
    bus.resp_ready = 1'b1;
    cyc();
    bus.resp_ready = 1'b0;
  endtask

  task automatic test_config_write();
    issue(0, A0, ACC_R, PRIV_U);
    conf[0] = CFG0_OFF;
    cyc();
    nvec++;
    if (bus.resp_valid !== 1'b1 || bus.resp_allow !== 1'b0 ||
        bus.resp_id !== 1'b0) begin
      nerr++;
      $display("FAIL cfg_write v=%b al=%b id=%b want 1 0 0",
               bus.resp_valid, bus.resp_allow, bus.resp_id);
    end
    conf[0] = CFG0;
    bus.resp_ready = 1'b1;
    cyc();
    bus.resp_ready = 1'b0;
  endtask

`ifdef PMP_ARB_FAULT_LOG_EN
  task automatic test_fault();
    fault_clear = 1'b1;
    cyc();
    fault_clear = 1'b0;
    nvec++;
    if (fault_valid !== 1'b0) begin
      nerr++;
      $display("FAIL fault_clear got=%b want 0", fault_valid);
    end
    issue(1, A1, ACC_R, PRIV_U);
    fault_clear = 1'b1;
    cyc();
    fault_clear = 1'b0;
    nvec++;
    if (fault_valid !== 1'b0) begin
      nerr++;
      $display("FAIL fault_clear_wins got=%b want 0",
               fault_valid);
    end
    bus.resp_ready = 1'b1;
    cyc();
    bus.resp_ready = 1'b0;
    issue(0, A2_OUT, ACC_R, PRIV_U);
    cyc();
    nvec++;
    if (fault_valid !== 1'b1 || fault_addr !== A2_OUT ||
        fault_id !== 1'b0) begin
      nerr++;
      $display("FAIL fault_relog v=%b a=%h id=%b want 1 %h 0",
               fault_valid, fault_addr, fault_id, A2_OUT);
    end
    bus.resp_ready = 1'b1;
    cyc();
    bus.resp_ready = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_flush();
    test_config_write();
`ifdef PMP_ARB_FAULT_LOG_EN
    test_fault();
`endif
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end
endmodule
